// File: rtl/rd_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rd_empty_ctrl
// Description : Read-side pointer and status controller for an asynchronous
//               FIFO.
//
//               The block brings the Gray-coded write pointer into the read
//               clock domain through a two-flop synchroniser. It keeps the
//               binary and Gray read pointers, and it produces registered
//               empty, almost-empty, occupancy and sticky underflow flags.
//
// Parameters  : ADDR_SIZE  - log2 of the FIFO depth; pointers are
//                            ADDR_SIZE+1 bits wide.
//               AE_THRESH  - almost-empty threshold in entries
//                            (0 .. 2^ADDR_SIZE-1).
//
// Ports       : rd_clk          in   read-domain clock (rising edge)
//               rd_rst          in   asynchronous active-high reset
//               rd_inc          in   read request (ignored while empty)
//               rd_uf_clr       in   synchronous clear of rd_underflow
//               wr_ptr          in   Gray write pointer (write clock domain)
//               rd_addr         out  binary RAM read address
//               rd_ptr          out  registered Gray read pointer
//               rd_empty        out  registered empty flag
//               rd_almost_empty out  registered occupancy <= AE_THRESH
//               rd_count        out  registered occupancy, 0 .. 2^ADDR_SIZE
//               rd_underflow    out  sticky flag for a read while empty
//
// Revision    : 1.0 - initial release
// ============================================================================
module rd_empty_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_inc,
  input  logic                 rd_uf_clr,
  input  logic [ADDR_SIZE:0]   wr_ptr,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [ADDR_SIZE:0]   rd_ptr,
  output logic                 rd_empty,
  output logic                 rd_almost_empty,
  output logic [ADDR_SIZE:0]   rd_count,
  output logic                 rd_underflow
);

  localparam logic [ADDR_SIZE:0] C_AE_THRESH = (ADDR_SIZE + 1)'(AE_THRESH);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [ADDR_SIZE:0] r_q1_wptr;   // first synchroniser stage; metastable
  logic [ADDR_SIZE:0] r_q2_wptr;   // second synchroniser stage; safe to use
  logic [ADDR_SIZE:0] r_bin;       // binary read pointer
  logic [ADDR_SIZE:0] r_ptr;       // Gray read pointer
  logic               r_empty;
  logic               r_almost_empty;
  logic [ADDR_SIZE:0] r_count;
  logic               r_underflow;

  // --------------------------------------------------------------------------
  // Combinational next-state
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic [ADDR_SIZE:0] w_bin_next;
  logic [ADDR_SIZE:0] w_gray_next;
  logic [ADDR_SIZE:0] w_wbin_sync;
  logic [ADDR_SIZE:0] w_count_next;
  logic               w_empty_next;
  logic               w_almost_empty_next;
  logic               w_underflow_set;

  // A read is honoured only against the registered empty flag. This keeps
  // the accepted read independent of the write pointer in the same cycle.
  assign w_accept        = rd_inc & ~r_empty;
  assign w_underflow_set = rd_inc & r_empty;

  // The pointer wraps naturally at 2^(ADDR_SIZE+1). The extra MSB tells a
  // full FIFO apart from an empty one.
  assign w_bin_next  = r_bin + {{ADDR_SIZE{1'b0}}, w_accept};
  assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

  // Gray-to-binary conversion of the synchronised write pointer. Each binary
  // bit is the parity of the Gray bits from the MSB down to that position.
  for (genvar i = 0; i <= ADDR_SIZE; i++) begin : g_gray2bin
    assign w_wbin_sync[i] = ^r_q2_wptr[ADDR_SIZE:i];
  end

  // Modular subtraction gives the occupancy directly. A full FIFO (MSB
  // differs, lower bits equal) comes out as exactly 2^ADDR_SIZE.
  assign w_count_next        = w_wbin_sync - w_bin_next;
  assign w_empty_next        = (w_gray_next == r_q2_wptr);
  assign w_almost_empty_next = (w_count_next <= C_AE_THRESH);

  // --------------------------------------------------------------------------
  // Write-pointer synchroniser
  // --------------------------------------------------------------------------
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_q1_wptr <= '0;
      r_q2_wptr <= '0;
    end else begin
      r_q1_wptr <= wr_ptr;
      r_q2_wptr <= r_q1_wptr;
    end
  end

  // --------------------------------------------------------------------------
  // Read pointer and status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_count        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= w_bin_next;
      r_ptr          <= w_gray_next;
      r_empty        <= w_empty_next;
      r_almost_empty <= w_almost_empty_next;
      r_count        <= w_count_next;
      // A new underflow on the same edge as a clear must stay visible.
      if (w_underflow_set) begin
        r_underflow <= 1'b1;
      end else if (rd_uf_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all taken straight from registers
  // --------------------------------------------------------------------------
  assign rd_addr         = r_bin[ADDR_SIZE-1:0];
  assign rd_ptr          = r_ptr;
  assign rd_empty        = r_empty;
  assign rd_almost_empty = r_almost_empty;
  assign rd_count        = r_count;
  assign rd_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rd_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_empty_ctrl
// Description : Self-checking bench for rd_empty_ctrl (ADDR_SIZE=4,
//               AE_THRESH=2). A queue-based occupancy model is checked every
//               cycle. Directed steps also check hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_empty_ctrl;

  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_inc = 1'b0;
  logic          rd_uf_clr = 1'b0;
  logic [AS:0]   wr_ptr;
  logic [AS-1:0] rd_addr;
  logic [AS:0]   rd_ptr;
  logic          rd_empty;
  logic          rd_almost_empty;
  logic [AS:0]   rd_count;
  logic          rd_underflow;

  int wbin = 0;          // write pointer in binary, as the writer sees it
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [AS:0] to_gray(input int b);
    logic [AS:0] v;
    v = (AS + 1)'(b);
    return v ^ (v >> 1);
  endfunction

  assign wr_ptr = to_gray(wbin);

  rd_empty_ctrl #(.ADDR_SIZE(AS), .AE_THRESH(AE)) dut (
    .rd_clk          (clk),
    .rd_rst          (rst),
    .rd_inc          (rd_inc),
    .rd_uf_clr       (rd_uf_clr),
    .wr_ptr          (wr_ptr),
    .rd_addr         (rd_addr),
    .rd_ptr          (rd_ptr),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_count        (rd_count),
    .rd_underflow    (rd_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model. Each edge sees the write pointer value that was
  // presented two edges earlier; occupancy is plain modular arithmetic.
  // --------------------------------------------------------------------------
  int m_rbin  = 0;
  int m_count = 0;
  int m_empty = 1;
  int m_ae    = 1;
  int m_uf    = 0;
  int wq[$]   = '{0, 0};
  int m_ws;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rbin = 0; m_count = 0; m_empty = 1; m_ae = 1; m_uf = 0;
      wq = '{0, 0};
    end else begin
      m_ws = wq.pop_front();
      wq.push_back(wbin);
      if (rd_inc && m_empty == 1) m_uf = 1;
      else if (rd_uf_clr)         m_uf = 0;
      if (rd_inc && m_empty == 0) m_rbin = (m_rbin + 1) % PMOD;
      m_count = (m_ws - m_rbin + PMOD) % PMOD;
      m_empty = (m_count == 0) ? 1 : 0;
      m_ae    = (m_count <= AE) ? 1 : 0;
    end
  end

  // Compare process: 1 time unit after each rising edge.
  logic [AS:0] prev_ptr = '0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("rd_count",        int'(rd_count),        m_count);
      chk("rd_empty",        int'(rd_empty),        m_empty);
      chk("rd_almost_empty", int'(rd_almost_empty), m_ae);
      chk("rd_underflow",    int'(rd_underflow),    m_uf);
      chk("rd_ptr",          int'(rd_ptr),          int'(to_gray(m_rbin)));
      chk("rd_addr",         int'(rd_addr),         m_rbin % DEPTH);
      chk("count_le_depth",  int'(rd_count <= (AS + 1)'(DEPTH)), 1);
      chk("ptr_one_bit",     int'($countones(rd_ptr ^ prev_ptr) <= 1), 1);
    end
    prev_ptr = rd_ptr;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Power-up reset.
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_empty", int'(rd_empty), 1);
    chk("rst_ptr",   int'(rd_ptr),   0);
    chk("rst_count", int'(rd_count), 0);
    chk("rst_ae",    int'(rd_almost_empty), 1);
    chk("rst_uf",    int'(rd_underflow), 0);
    rst = 1'b0;

    // Three entries written; status appears after the third edge.
    wbin = 3;                      // Gray 5'b00010
    cyc(); chk("lat_e1_empty", int'(rd_empty), 1);
    cyc(); chk("lat_e2_empty", int'(rd_empty), 1);
    cyc();
    chk("lat_e3_empty", int'(rd_empty), 0);
    chk("lat_e3_count", int'(rd_count), 3);
    chk("lat_e3_ae",    int'(rd_almost_empty), 0);

    // Drain three entries.
    rd_inc = 1'b1;
    cyc(); chk("rd1_count", int'(rd_count), 2); chk("rd1_ae", int'(rd_almost_empty), 1);
    cyc(); chk("rd2_count", int'(rd_count), 1); chk("rd2_empty", int'(rd_empty), 0);
    cyc(); chk("rd3_count", int'(rd_count), 0); chk("rd3_empty", int'(rd_empty), 1);
    rd_inc = 1'b0;
    chk("rd3_ptr",  int'(rd_ptr), 2);
    chk("rd3_addr", int'(rd_addr), 3);

    // Underflow: set, hold, clear, and set-beats-clear.
    rd_inc = 1'b1;
    cyc(); rd_inc = 1'b0;
    chk("uf_ptr_hold", int'(rd_ptr), 2);
    chk("uf_set",      int'(rd_underflow), 1);
    cyc(); chk("uf_held", int'(rd_underflow), 1);
    rd_uf_clr = 1'b1;
    cyc(); chk("uf_clr", int'(rd_underflow), 0);
    rd_inc = 1'b1;
    cyc(); chk("uf_set_wins", int'(rd_underflow), 1);
    rd_inc = 1'b0; rd_uf_clr = 1'b0;
    chk("uf_set_wins_ptr", int'(rd_ptr), 2);

    // Reset between edges acts at once.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_empty", int'(rd_empty), 1);
    chk("arst_ptr",   int'(rd_ptr), 0);
    chk("arst_addr",  int'(rd_addr), 0);
    chk("arst_count", int'(rd_count), 0);
    chk("arst_ae",    int'(rd_almost_empty), 1);
    chk("arst_uf",    int'(rd_underflow), 0);

    // Full occupancy after reset, then a complete drain and one wrap.
    wbin = 16;                     // Gray 5'b11000
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    chk("full_count", int'(rd_count), 16);
    chk("full_empty", int'(rd_empty), 0);
    chk("full_ae",    int'(rd_almost_empty), 0);
    rd_inc = 1'b1;
    repeat (16) cyc();
    rd_inc = 1'b0;
    chk("drain_ptr",   int'(rd_ptr), 24);
    chk("drain_addr",  int'(rd_addr), 0);
    chk("drain_empty", int'(rd_empty), 1);
    chk("drain_count", int'(rd_count), 0);
    wbin = 17;                     // Gray 5'b11001
    cyc(); cyc(); cyc();
    chk("wrap_count", int'(rd_count), 1);
    chk("wrap_addr",  int'(rd_addr), 0);
    rd_inc = 1'b1;
    cyc(); rd_inc = 1'b0;
    chk("wrap_rd_addr",  int'(rd_addr), 1);
    chk("wrap_rd_ptr",   int'(rd_ptr), 25);
    chk("wrap_rd_empty", int'(rd_empty), 1);

    // Random traffic. The writer never overfills its view of the FIFO.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1 && ((wbin - m_rbin + PMOD) % PMOD) < DEPTH)
        wbin = (wbin + 1) % PMOD;
      rd_inc    = ($urandom_range(0, 2) != 0);
      rd_uf_clr = ($urandom_range(0, 7) == 0);
      cyc();
    end
    rd_inc = 1'b0; rd_uf_clr = 1'b0;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rd_empty_ctrl.md
RD_EMPTY_CTRL -- requirements
Module: rd_empty_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 4: FIFO depth is 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
REQ-002 Parameter AE_THRESH, default 2: almost-empty threshold in entries; legal range 0..2^ADDR_SIZE-1.
REQ-003 rd_clk  input  1  read-domain clock; the block has one clock and all state is on the rising edge.
REQ-004 rd_rst  input  1  asynchronous, active-high reset.
REQ-005 rd_inc  input  1  read request; a read is accepted only when rd_empty=0.
REQ-006 rd_uf_clr  input  1  synchronous clear of rd_underflow.
REQ-007 wr_ptr  input  ADDR_SIZE+1  Gray-coded write pointer from the write domain; asynchronous to rd_clk.
REQ-008 rd_addr  output  ADDR_SIZE  binary RAM read address.
REQ-009 rd_ptr  output  ADDR_SIZE+1  registered Gray-coded read pointer, passed to the write domain.
REQ-010 rd_empty  output  1  registered FIFO-empty flag.
REQ-011 rd_almost_empty  output  1  registered flag, set when occupancy <= AE_THRESH.
REQ-012 rd_count  output  ADDR_SIZE+1  registered occupancy as seen by the read domain, range 0..2^ADDR_SIZE.
REQ-013 rd_underflow  output  1  sticky flag for a read attempted while empty.

Function
REQ-014 The block SHALL synchronise wr_ptr through two rd_clk flops, rd_q1_wptr then rd_q2_wptr; no other logic SHALL read rd_q1_wptr.
REQ-015 The block SHALL compute rd_bin_next = rd_bin + (rd_inc & ~rd_empty), modulo 2^(ADDR_SIZE+1), with natural wrap-around.
REQ-016 The block SHALL compute rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next; rd_bin and rd_ptr SHALL both register on every edge.
REQ-017 rd_addr SHALL equal rd_bin[ADDR_SIZE-1:0], combinationally from the register.
REQ-018 rd_empty SHALL register (rd_gray_next == rd_q2_wptr); a read that consumes the last entry sets rd_empty on the same edge.
REQ-019 The block SHALL convert rd_q2_wptr from Gray to binary combinationally (wbin_sync: each bit i is the XOR of Gray bits ADDR_SIZE..i).
REQ-020 rd_count SHALL register (wbin_sync - rd_bin_next) modulo 2^(ADDR_SIZE+1).
REQ-021 rd_almost_empty SHALL register (count_next <= AE_THRESH), where count_next is the value being loaded into rd_count.
REQ-022 Write-to-read latency: a wr_ptr change stable before edge N appears in rd_q2_wptr after edge N+1, and rd_empty, rd_count and rd_almost_empty update at edge N+2.
REQ-023 rd_underflow SHALL set on any edge where rd_inc=1 and rd_empty=1; that rejected read SHALL NOT move rd_bin or rd_ptr.
REQ-024 rd_underflow SHALL hold until an edge with rd_uf_clr=1; if a set and a clear occur on the same edge, set SHALL win.
REQ-025 Full occupancy: wbin_sync - rd_bin = 2^ADDR_SIZE SHALL give rd_count = 2^ADDR_SIZE and rd_empty=0 (MSB differs, lower bits equal).
REQ-026 No output SHALL be combinational from wr_ptr.

Reset
REQ-027 While rd_rst=1 the block SHALL force, without waiting for a clock edge:
- rd_q1_wptr=0, rd_q2_wptr=0, rd_bin=0, rd_ptr=0, rd_addr=0
- rd_count=0, rd_empty=1, rd_almost_empty=1, rd_underflow=0
REQ-028 Reset asserted mid-read SHALL abandon the read; the first edge after deassertion SHALL evaluate from the reset state.

Verification
REQ-029 The bench SHALL cover these directed scenarios (ADDR_SIZE=4, AE_THRESH=2):
- Assert rd_rst between clock edges -> all outputs take their reset values immediately; rd_empty=1, rd_ptr=5'b00000.
- After reset, hold wr_ptr=5'b00010 (binary 3) before edge 1 -> rd_empty=0, rd_count=3, rd_almost_empty=0 after edge 3, not earlier.
- From the previous state, rd_inc=1 for 3 edges -> rd_count goes 2, 1, 0; rd_almost_empty=1 after the first read; rd_empty=1 after the third; rd_ptr=5'b00010, rd_addr=3.
- With rd_empty=1, pulse rd_inc -> rd_ptr unchanged; rd_underflow=1 next edge and held; rd_uf_clr=1 alone clears it; rd_inc=1 and rd_uf_clr=1 on the same edge -> rd_underflow stays 1.
- From reset, wr_ptr=5'b11000 (binary 16) -> rd_count=16; 16 reads -> rd_bin=16, rd_ptr=5'b11000, rd_addr=0, rd_empty=1; a further write wraps to rd_addr=0 correctly.
- Random wr_ptr Gray increments against random rd_inc -> rd_count never exceeds 16, rd_ptr changes by at most one bit per edge, and no read is accepted while empty.
